// File: rtl/comparand_serializer.sv
// Serializes an operand pair MSB-first for a bit-serial comparator, with a
// one-cycle load latency, downstream stall and gap-free back-to-back words.
module comparand_serializer #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [width-1:0] a_in,
  input  logic [width-1:0] b_in,
  input  logic             stall,
  output logic             ready,
  output logic             a_bit,
  output logic             b_bit,
  output logic             bit_valid,
  output logic             first_bit,
  output logic             last_bit
);
  localparam int NUM_LANES = 2;
  localparam int CW = (width > 1) ? $clog2(width) : 1;
  localparam logic [CW-1:0] LAST = CW'(width - 1);

  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]                       cnt;
  logic                                accept, advance, clear;
  logic [NUM_LANES-1:0][width-1:0]     din;
  logic [NUM_LANES-1:0]                msb;

  assign din = {a_in, b_in};

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else       state <= state_nxt;

  always_comb begin
    state_nxt = state;
    bit_valid = (state == SHIFT);
    first_bit = bit_valid && (cnt == '0);
    last_bit  = bit_valid && (cnt == LAST);
    a_bit     = bit_valid && msb[1];
    b_bit     = bit_valid && msb[0];
    ready     = (state == IDLE) || (last_bit && !stall);
    accept    = load && ready;
    advance   = (state == SHIFT) && !stall;
    clear     = 1'b0;
    if (accept)
      state_nxt = SHIFT;
    else if (advance && last_bit) begin
      state_nxt = IDLE;
      clear     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset)                   cnt <= '0;
    else if (accept || clear)    cnt <= '0;
    else if (advance)            cnt <= cnt + CW'(1);

  // One shifter per operand; a load always wins over the final shift.
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    comparand_serializer_lane #(.width(width)) u_lane (
      .clk   (clk),
      .reset (reset),
      .load  (accept),
      .shift (advance),
      .clear (clear),
      .din   (din[l]),
      .msb   (msb[l])
    );
  end
endmodule

// Single operand MSB-first shift register.
module comparand_serializer_lane #(
  parameter int width = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             clear,
  input  logic [width-1:0] din,
  output logic             msb
);
  logic [width-1:0] sh;

  always_ff @(posedge clk or posedge reset)
    if (reset)      sh <= '0;
    else if (load)  sh <= din;
    else if (clear) sh <= '0;
    else if (shift) sh <= sh << 1;

  assign msb = sh[width-1];
endmodule

// File: tb/tb_comparand_serializer.sv
// Scoreboard bench: accepted words expand into per-bit expectations that a
// negedge monitor consumes; a width=1 instance gets a short directed check.
module tb_comparand_serializer;
  localparam int W = 4;

  logic         clk = 0, rst = 1, load = 0, stall = 0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic         ready, a_bit, b_bit, bit_valid, first_bit, last_bit;

  logic         load1 = 0, stall1 = 0;
  logic [0:0]   a1 = '0, b1 = '0;
  logic         ready1, a_bit1, b_bit1, bit_valid1, first_bit1, last_bit1;

  int total = 0, bad = 0;

  typedef struct packed { logic a, b, f, l; } exp_t;
  exp_t q[$];
  logic exp_ready = 1'b1;

  comparand_serializer #(.width(W)) dut (
    .clk(clk), .reset(rst), .load(load), .a_in(a_in), .b_in(b_in),
    .stall(stall), .ready(ready), .a_bit(a_bit), .b_bit(b_bit),
    .bit_valid(bit_valid), .first_bit(first_bit), .last_bit(last_bit));

  comparand_serializer #(.width(1)) dut1 (
    .clk(clk), .reset(rst), .load(load1), .a_in(a1), .b_in(b1),
    .stall(stall1), .ready(ready1), .a_bit(a_bit1), .b_bit(b_bit1),
    .bit_valid(bit_valid1), .first_bit(first_bit1), .last_bit(last_bit1));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [5:0] act, input logic [5:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got rdy/vld/a/b/f/l=%b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted word becomes W expected bit periods, MSB first.
  always @(posedge clk)
    if (!rst && load && exp_ready)
      for (int i = W - 1; i >= 0; i--)
        q.push_back('{a_in[i], b_in[i], i == W - 1, i == 0});

  // Monitor: queue head is the bit on the wire; it is consumed unless stalled.
  always @(negedge clk) begin
    logic [5:0] e;
    if (rst || q.size() == 0) begin
      e = 6'b100000;
      exp_ready = 1'b1;
    end else begin
      exp_ready = (q.size() == 1) && !stall;
      e = {exp_ready, 1'b1, q[0].a, q[0].b, q[0].f, q[0].l};
    end
    chk("stream", {ready, bit_valid, a_bit, b_bit, first_bit, last_bit}, e);
    if (!rst && q.size() > 0 && !stall) void'(q.pop_front());
  end

  task automatic word(input logic [W-1:0] a, input logic [W-1:0] b);
    load = 1; a_in = a; b_in = b;
    @(posedge clk); #1 load = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;

    // single word a/b
    word(4'ha, 4'hb);
    repeat (5) @(posedge clk); #1;

    // back-to-back with load held high
    load = 1; a_in = 4'ha; b_in = 4'hb;
    @(posedge clk); #1 a_in = 4'h3; b_in = 4'h3;
    repeat (4) @(posedge clk); #1 load = 0;
    repeat (5) @(posedge clk); #1;

    // stall three cycles during bit 2
    word(4'ha, 4'hb);
    @(posedge clk); #1 stall = 1;
    repeat (3) @(posedge clk); #1 stall = 0;
    repeat (4) @(posedge clk); #1;

    // load pulse while busy must be ignored
    word(4'ha, 4'hb);
    load = 1; a_in = 4'hf; b_in = 4'hf;
    @(posedge clk); #1 load = 0;
    repeat (4) @(posedge clk); #1;

    // asynchronous reset mid-word
    word(4'ha, 4'hb);
    @(posedge clk); #3 rst = 1;
    #1 chk("async_rst", {ready, bit_valid, a_bit, b_bit, first_bit, last_bit}, 6'b100000);
    q.delete();
    @(posedge clk); #1 rst = 0;
    word(4'h9, 4'h6);
    repeat (5) @(posedge clk); #1;

    // randomized traffic, stall also toggled while idle
    repeat (400) begin
      load  = ($urandom % 3) == 0;
      a_in  = W'($urandom);
      b_in  = W'($urandom);
      stall = ($urandom % 4) == 0;
      @(posedge clk); #1;
    end
    load = 0; stall = 0;
    repeat (10) @(posedge clk); #1;
    chk("drained", {5'b0, q.size() == 0}, 6'b000001);

    // width=1 instance: back-to-back then stalled single-bit word
    load1 = 1; a1 = 1'b1; b1 = 1'b0;
    @(negedge clk);
    chk("w1_idle", {ready1, bit_valid1, a_bit1, b_bit1, first_bit1, last_bit1}, 6'b100000);
    @(posedge clk); #1 a1 = 1'b0; b1 = 1'b1;
    @(negedge clk);
    chk("w1_bit0", {ready1, bit_valid1, a_bit1, b_bit1, first_bit1, last_bit1}, 6'b111011);
    @(posedge clk); #1 load1 = 0;
    @(negedge clk);
    chk("w1_b2b", {ready1, bit_valid1, a_bit1, b_bit1, first_bit1, last_bit1}, 6'b110111);
    @(posedge clk); #1 load1 = 1; a1 = 1'b1; b1 = 1'b1;
    @(negedge clk);
    chk("w1_ret_idle", {ready1, bit_valid1, a_bit1, b_bit1, first_bit1, last_bit1}, 6'b100000);
    @(posedge clk); #1 load1 = 0; stall1 = 1;
    @(negedge clk);
    chk("w1_stalled", {ready1, bit_valid1, a_bit1, b_bit1, first_bit1, last_bit1}, 6'b011111);
    @(posedge clk); #1 stall1 = 0;
    @(negedge clk);
    chk("w1_held", {ready1, bit_valid1, a_bit1, b_bit1, first_bit1, last_bit1}, 6'b111111);
    @(posedge clk); #1;
    @(negedge clk);
    chk("w1_done", {ready1, bit_valid1, a_bit1, b_bit1, first_bit1, last_bit1}, 6'b100000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
